// File: rtl/tt_bin_clock_pkg.sv
// Shared definitions for the binary clock button front-end and clock core.
//   ID_*          : 2-bit command codes on the core's hour/minute/seconds _id inputs
//   chan_state_e  : per-field button channel state
//   cnt_w()       : counter width for a cycle-count parameter, never below 1 bit
package tt_bin_clock_pkg;

  localparam logic [1:0] ID_IDLE = 2'b00;
  localparam logic [1:0] ID_INC  = 2'b01;
  localparam logic [1:0] ID_DEC  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HELD_INC = 2'd1,
    ST_HELD_DEC = 2'd2,
    ST_LOCK     = 2'd3
  } chan_state_e;

  function automatic int cnt_w(input int v);
    return $clog2(v < 2 ? 2 : v);
  endfunction

endpackage

// File: rtl/tt_bin_clock_btn_chan.sv
// One clock field's button channel: synchronises and debounces the inc/dec
// buttons, then turns debounced presses into one-cycle command pulses with
// auto-repeat while held.
//   clk_i, rst_i : system clock, async active-high reset
//   btn_i        : raw buttons, [1]=dec [0]=inc
//   id_o         : registered command code (ID_IDLE / ID_INC / ID_DEC)
module tt_bin_clock_btn_chan
  import tt_bin_clock_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 12000,
  parameter int REPEAT_PERIOD   = 3000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] btn_i,
  output logic [1:0] id_o
);

  localparam int DBW = cnt_w(DEBOUNCE_CYCLES);
  localparam int RPW = cnt_w(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPW-1:0] RD_LOAD = RPW'(REPEAT_DELAY - 1);
  localparam logic [RPW-1:0] RP_LOAD = RPW'(REPEAT_PERIOD - 1);

  logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0][DBW-1:0]         db_cnt_q, db_cnt_d;
  logic [1:0]                  lvl_q, lvl_d;
  chan_state_e                 state_q, state_d;
  logic [RPW-1:0]              rep_q, rep_d;
  logic [1:0]                  id_q, id_d;

  logic inc_d, dec_d;
  assign inc_d = lvl_q[0];
  assign dec_d = lvl_q[1];

  // Synchroniser shift and debounce; the level only flips after the
  // synchronised value has disagreed with it on DEBOUNCE_CYCLES edges in a row.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      sync_d[b]   = {sync_q[b][SYNC_STAGES-2:0], btn_i[b]};
      lvl_d[b]    = lvl_q[b];
      db_cnt_d[b] = '0;
      if (sync_q[b][SYNC_STAGES-1] != lvl_q[b]) begin
        if (db_cnt_q[b] == DB_LAST) lvl_d[b] = ~lvl_q[b];
        else                        db_cnt_d[b] = db_cnt_q[b] + DBW'(1);
      end
    end
  end

  // Channel FSM; release and lock take priority over any due repeat pulse.
  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    id_d    = ID_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (inc_d && dec_d) begin
          state_d = ST_LOCK;
        end else if (inc_d || dec_d) begin
          state_d = inc_d ? ST_HELD_INC : ST_HELD_DEC;
          id_d    = inc_d ? ID_INC : ID_DEC;
          rep_d   = RD_LOAD;
        end
      end
      ST_HELD_INC, ST_HELD_DEC: begin
        if (!inc_d && !dec_d) begin
          state_d = ST_IDLE;
        end else if (inc_d && dec_d) begin
          state_d = ST_LOCK;
        end else if (inc_d != (state_q == ST_HELD_INC)) begin
          // Direction swapped within one cycle: behaves like a fresh press.
          state_d = inc_d ? ST_HELD_INC : ST_HELD_DEC;
          id_d    = inc_d ? ID_INC : ID_DEC;
          rep_d   = RD_LOAD;
        end else if (rep_q == '0) begin
          id_d  = (state_q == ST_HELD_INC) ? ID_INC : ID_DEC;
          rep_d = RP_LOAD;
        end else begin
          rep_d = rep_q - RPW'(1);
        end
      end
      ST_LOCK: begin
        if (!inc_d && !dec_d) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      db_cnt_q <= '0;
      lvl_q    <= '0;
      state_q  <= ST_IDLE;
      rep_q    <= '0;
      id_q     <= ID_IDLE;
    end else begin
      sync_q   <= sync_d;
      db_cnt_q <= db_cnt_d;
      lvl_q    <= lvl_d;
      state_q  <= state_d;
      rep_q    <= rep_d;
      id_q     <= id_d;
    end
  end

  assign id_o = id_q;

endmodule

// File: rtl/tt_bin_clock_buttons.sv
// Button front-end for the binary clock core: three independent channels
// (hour, minute, seconds) each turning raw inc/dec buttons into _id codes.
//   clk_i, rst_i   : system clock, async active-high reset
//   btn_inc_i      : raw increment buttons, [2]=hour [1]=minute [0]=seconds
//   btn_dec_i      : raw decrement buttons, same mapping
//   hour_id_o, minute_id_o, seconds_id_o : command codes to the core
module tt_bin_clock_buttons
  import tt_bin_clock_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 12000,
  parameter int REPEAT_PERIOD   = 3000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] btn_inc_i,
  input  logic [2:0] btn_dec_i,
  output logic [1:0] hour_id_o,
  output logic [1:0] minute_id_o,
  output logic [1:0] seconds_id_o
);

  logic [2:0][1:0] id;

  for (genvar g = 0; g < 3; g++) begin : g_chan
    tt_bin_clock_btn_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .btn_i({btn_dec_i[g], btn_inc_i[g]}),
      .id_o (id[g])
    );
  end

  assign hour_id_o    = id[2];
  assign minute_id_o  = id[1];
  assign seconds_id_o = id[0];

endmodule

// File: tb/tb_tt_bin_clock_buttons.sv
// Randomised + directed bench with a cycle-level reference model and a
// scoreboard queue of expected {hour, minute, seconds} codes.
module tb_tt_bin_clock_buttons;
  localparam int S  = 2;
  localparam int DC = 4;
  localparam int RD = 16;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] inc = '0, dec = '0;
  logic [1:0] hour_id, minute_id, seconds_id;

  tt_bin_clock_buttons #(
    .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk_i(clk), .rst_i(rst), .btn_inc_i(inc), .btn_dec_i(dec),
    .hour_id_o(hour_id), .minute_id_o(minute_id), .seconds_id_o(seconds_id)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [5:0] exp_q[$];

  // Reference model state. Buttons 0..2 are inc[field], 3..5 dec[field].
  logic [5:0] hist[$];     // raw samples still travelling through the synchroniser
  logic [5:0] lvl;         // debounced levels
  int         run[6];      // consecutive edges where the delayed raw disagrees with lvl
  int         mode[3];     // 0 idle, 1 holding inc, 2 holding dec, 3 locked
  int         next_t[3];   // absolute edge number of the next repeat pulse
  int         t;           // edges since reset release
  logic [2:0] cur_inc, cur_dec;

  function automatic string fname(input int f);
    return (f == 2) ? "hour_id" : (f == 1) ? "minute_id" : "seconds_id";
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < S; k++) hist.push_back('0);
    lvl = '0;
    t   = 0;
    for (int b = 0; b < 6; b++) run[b] = 0;
    for (int f = 0; f < 3; f++) begin mode[f] = 0; next_t[f] = 0; end
  endtask

  // Expected outputs right after the next rising edge, given the inputs the DUT samples on it.
  task automatic model_advance();
    logic [5:0] delayed, out;
    logic       i, d;
    int         want;
    t++;
    out = '0;
    hist.push_back({cur_dec, cur_inc});
    delayed = hist.pop_front();
    for (int f = 0; f < 3; f++) begin
      i = lvl[f];
      d = lvl[3+f];
      want = i ? 1 : 2;
      case (mode[f])
        0: if (i && d) mode[f] = 3;
           else if (i || d) begin mode[f] = want; out[2*f +: 2] = 2'(want); next_t[f] = t + RD; end
        1, 2: if (!i && !d) mode[f] = 0;
           else if (i && d) mode[f] = 3;
           else if (want != mode[f]) begin mode[f] = want; out[2*f +: 2] = 2'(want); next_t[f] = t + RD; end
           else if (t == next_t[f]) begin out[2*f +: 2] = 2'(mode[f]); next_t[f] = t + RP; end
        default: if (!i && !d) mode[f] = 0;
      endcase
    end
    for (int b = 0; b < 6; b++) begin
      if (delayed[b] == lvl[b]) run[b] = 0;
      else begin
        run[b]++;
        if (run[b] == DC) begin lvl[b] = ~lvl[b]; run[b] = 0; end
      end
    end
    exp_q.push_back(out);
  endtask

  // Monitor: one expected entry per post-reset cycle.
  logic [5:0] mon_exp, mon_act;
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {hour_id, minute_id, seconds_id};
      for (int f = 0; f < 3; f++) begin
        vectors++;
        if (mon_act[2*f +: 2] !== mon_exp[2*f +: 2]) begin
          miscompares++;
          $display("FAIL %s t=%0d (%0t): got %b expected %b", fname(f), t,
                   $time, mon_act[2*f +: 2], mon_exp[2*f +: 2]);
        end
      end
    end
  end

  task automatic step(input logic [2:0] ni, input logic [2:0] nd);
    @(posedge clk); #1;
    model_advance();
    cur_inc = ni; cur_dec = nd;
    inc = ni; dec = nd;
  endtask

  task automatic hold(input logic [2:0] ni, input logic [2:0] nd, input int n);
    repeat (n) step(ni, nd);
  endtask

  // Mid-cycle reset: outputs must clear without waiting for a clock edge.
  task automatic reset_with(input logic [2:0] ni, input logic [2:0] nd);
    logic [5:0] act;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    act = {hour_id, minute_id, seconds_id};
    for (int f = 0; f < 3; f++) begin
      vectors++;
      if (act[2*f +: 2] !== 2'b00) begin
        miscompares++;
        $display("FAIL async_reset_%s: got %b expected 00", fname(f), act[2*f +: 2]);
      end
    end
    exp_q.delete();
    model_reset();
    inc = ni; dec = nd; cur_inc = ni; cur_dec = nd;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [2:0] r_inc, r_dec;
  int         r_len;

  initial begin
    model_reset();
    cur_inc = 3'b100; cur_dec = '0;
    inc = 3'b100; dec = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // hour inc held through reset release
    hold(3'b100, 3'b000, 12);
    hold(3'b000, 3'b000, 20);
    // 3-cycle bounce on minute dec
    hold(3'b000, 3'b010, 3);
    hold(3'b000, 3'b000, 15);
    // seconds inc held long enough for several repeats
    hold(3'b001, 3'b000, 56);
    hold(3'b000, 3'b000, 20);
    // minute lock, then staged release
    hold(3'b010, 3'b000, 20);
    hold(3'b010, 3'b010, 30);
    hold(3'b000, 3'b010, 20);
    hold(3'b000, 3'b000, 20);
    // hour direction swap in a single cycle
    hold(3'b100, 3'b000, 30);
    hold(3'b000, 3'b100, 40);
    hold(3'b000, 3'b000, 20);
    // all three fields together, reset mid-hold
    hold(3'b111, 3'b000, 20);
    reset_with(3'b111, 3'b000);
    hold(3'b111, 3'b000, 15);
    hold(3'b000, 3'b000, 15);
    // random: sparse button flips with varied hold lengths, occasional reset
    for (int s = 0; s < 220; s++) begin
      r_inc = cur_inc ^ 3'($urandom & $urandom & 32'h7);
      r_dec = cur_dec ^ 3'($urandom & $urandom & 32'h7);
      r_len = (($urandom & 32'h3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(4, 45));
      if ($urandom_range(0, 39) == 0) reset_with(r_inc, r_dec);
      hold(r_inc, r_dec, r_len);
    end
    hold(3'b000, 3'b000, 20);
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
